// File: rtl/csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR file and trap sequencer:
// CSR addresses, op encodings, FSM states, bit positions and write masks.
package csr_pkg;

    // CSR addresses
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    // csr_op encodings
    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    // Trap sequencer states
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    // Bit positions
    localparam int unsigned BIT_MIE  = 3;
    localparam int unsigned BIT_MPIE = 7;
    localparam int unsigned BIT_MEIE = 11;
    localparam int unsigned BIT_MEIP = 11;

    // mstatus.MPP is hard-wired to machine mode
    localparam logic [31:0] MSTATUS_RO_ONES = 32'h0000_1800;

    // Writable-bit masks, applied after the RW/RS/RC op
    localparam logic [31:0] WMASK_MSTATUS = (32'h1 << BIT_MIE) | (32'h1 << BIT_MPIE);
    localparam logic [31:0] WMASK_MIE     = 32'h1 << BIT_MEIE;
    localparam logic [31:0] WMASK_ALIGN4  = 32'hFFFF_FFFC;
    localparam logic [31:0] WMASK_FULL    = 32'hFFFF_FFFF;

endpackage

// File: rtl/csr_trap_unit_if.sv
// Datapath <-> CSR/trap unit signal bundle. The datapath is the master,
// the CSR/trap unit is the slave.
interface csr_trap_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            trap_req;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_tval;
    logic            mret_req;
    logic            ext_irq;
    logic            irq_pending;
    logic            busy;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output csr_op, csr_addr, csr_wdata, trap_req, trap_cause, trap_pc,
               trap_tval, mret_req, ext_irq,
        input  csr_rdata, csr_illegal, irq_pending, busy, redirect_valid,
               redirect_pc
    );

    modport slave (
        input  csr_op, csr_addr, csr_wdata, trap_req, trap_cause, trap_pc,
               trap_tval, mret_req, ext_irq,
        output csr_rdata, csr_illegal, irq_pending, busy, redirect_valid,
               redirect_pc
    );
endinterface

// File: rtl/csr_trap_unit_write_alu.sv
// CSR write-value computation: applies RW/RS/RC to the old value, then
// keeps only the writable bits, preserving the rest from the old value.
module csr_write_alu
    import csr_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  csr_op_e         i_op,
    input  logic [XLEN-1:0] i_old,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_mask,
    output logic [XLEN-1:0] o_new
);

    logic [XLEN-1:0] w_raw;

    // Raw op result followed by writable-bit merge
    always_comb begin
        w_raw = i_old;
        case (i_op)
            CSR_RW:  w_raw = i_wdata;
            CSR_RS:  w_raw = i_old | i_wdata;
            CSR_RC:  w_raw = i_old & ~i_wdata;
            default: w_raw = i_old;
        endcase
        o_new = (w_raw & i_mask) | (i_old & ~i_mask);
    end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap sequencer. Holds trap state, serves CSR
// reads/writes and issues a one-cycle PC redirect on trap entry and mret.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
    input logic            clk,
    input logic            rst,
    csr_trap_unit_if.slave bus
);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [XLEN-1:0] r_mstatus;     // only MIE/MPIE bits are ever non-zero
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_redirect_pc;

    csr_op_e         w_op;
    logic [XLEN-1:0] w_rdata;
    logic [XLEN-1:0] w_wmask;
    logic            w_mapped;
    logic            w_illegal;
    logic            w_csr_we;
    logic            w_accept_trap;
    logic            w_accept_mret;
    logic [XLEN-1:0] w_new;

    assign w_op = csr_op_e'(bus.csr_op);

    // Read mux, writable mask and address decode for the addressed CSR
    always_comb begin
        w_rdata  = '0;
        w_wmask  = '0;
        w_mapped = 1'b1;
        case (bus.csr_addr)
            CSR_MSTATUS:  begin w_rdata = r_mstatus | MSTATUS_RO_ONES; w_wmask = WMASK_MSTATUS; end
            CSR_MIE:      begin w_rdata = r_mie;      w_wmask = WMASK_MIE;    end
            CSR_MTVEC:    begin w_rdata = r_mtvec;    w_wmask = WMASK_ALIGN4; end
            CSR_MSCRATCH: begin w_rdata = r_mscratch; w_wmask = WMASK_FULL;   end
            CSR_MEPC:     begin w_rdata = r_mepc;     w_wmask = WMASK_ALIGN4; end
            CSR_MCAUSE:   begin w_rdata = r_mcause;   w_wmask = WMASK_FULL;   end
            CSR_MTVAL:    begin w_rdata = r_mtval;    w_wmask = WMASK_FULL;   end
            CSR_MIP:      w_rdata = {{(XLEN-1){1'b0}}, bus.ext_irq} << BIT_MEIP;
            CSR_MHARTID:  w_rdata = '0;
            default:      w_mapped = 1'b0;
        endcase
    end

    // Illegal-op decode; RS/RC with zero operand on mhartid is a pure read
    always_comb begin
        w_illegal = 1'b0;
        if (w_op != CSR_NONE) begin
            if (!w_mapped)
                w_illegal = 1'b1;
            else if (bus.csr_addr == CSR_MHARTID)
                w_illegal = (w_op == CSR_RW) || (bus.csr_wdata != '0);
        end
    end

    csr_write_alu #(
        .XLEN(XLEN)
    ) u_write_alu (
        .i_op    (w_op),
        .i_old   (w_rdata),
        .i_wdata (bus.csr_wdata),
        .i_mask  (w_wmask),
        .o_new   (w_new)
    );

    // Requests are only accepted in IDLE; trap wins over mret, both win over CSR writes
    assign w_accept_trap = (r_state == ST_IDLE) && bus.trap_req;
    assign w_accept_mret = (r_state == ST_IDLE) && !bus.trap_req && bus.mret_req;
    assign w_csr_we      = (r_state == ST_IDLE) && !bus.trap_req && !bus.mret_req &&
                           (w_op != CSR_NONE) && !w_illegal;

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and redirect handshake outputs
    always_comb begin
        w_state_nxt        = r_state;
        bus.busy           = 1'b0;
        bus.redirect_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.trap_req || bus.mret_req) w_state_nxt = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                bus.busy           = 1'b1;
                bus.redirect_valid = 1'b1;
                w_state_nxt        = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Trap entry, mret and CSR write updates of the register file
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus     <= '0;
            r_mie         <= '0;
            r_mtvec       <= MTVEC_RESET & WMASK_ALIGN4;
            r_mscratch    <= '0;
            r_mepc        <= '0;
            r_mcause      <= '0;
            r_mtval       <= '0;
            r_redirect_pc <= '0;
        end else if (w_accept_trap) begin
            r_mepc                <= bus.trap_pc & WMASK_ALIGN4;
            r_mcause              <= bus.trap_cause;
            r_mtval               <= bus.trap_tval;
            r_mstatus[BIT_MPIE]   <= r_mstatus[BIT_MIE];
            r_mstatus[BIT_MIE]    <= 1'b0;
            r_redirect_pc         <= r_mtvec & WMASK_ALIGN4;
        end else if (w_accept_mret) begin
            r_mstatus[BIT_MIE]    <= r_mstatus[BIT_MPIE];
            r_mstatus[BIT_MPIE]   <= 1'b1;
            r_redirect_pc         <= r_mepc;
        end else if (w_csr_we) begin
            case (bus.csr_addr)
                CSR_MSTATUS:  r_mstatus  <= w_new & WMASK_MSTATUS;
                CSR_MIE:      r_mie      <= w_new;
                CSR_MTVEC:    r_mtvec    <= w_new;
                CSR_MSCRATCH: r_mscratch <= w_new;
                CSR_MEPC:     r_mepc     <= w_new;
                CSR_MCAUSE:   r_mcause   <= w_new;
                CSR_MTVAL:    r_mtval    <= w_new;
                default: ;
            endcase
        end
    end

    assign bus.csr_rdata   = w_rdata;
    assign bus.csr_illegal = w_illegal;
    assign bus.redirect_pc = r_redirect_pc;
    assign bus.irq_pending = r_mstatus[BIT_MIE] & r_mie[BIT_MEIE] & bus.ext_irq;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit.
module tb_csr_trap_unit;
    import csr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    csr_trap_unit_if #(.XLEN(32)) bus ();

    csr_trap_unit #(
        .XLEN        (32),
        .MTVEC_RESET (32'h0000_0403)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.csr_op     = CSR_NONE;
        bus.csr_wdata  = '0;
        bus.trap_req   = 1'b0;
        bus.mret_req   = 1'b0;
        bus.trap_cause = '0;
        bus.trap_pc    = '0;
        bus.trap_tval  = '0;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        bus.csr_op   = CSR_NONE;
        bus.csr_addr = addr;
        #1;
        chk(tag, bus.csr_rdata, exp);
    endtask

    task automatic wr(input csr_op_e op, input logic [11:0] addr, input logic [31:0] wdata);
        bus.csr_op    = op;
        bus.csr_addr  = addr;
        bus.csr_wdata = wdata;
        tick();
        bus.csr_op    = CSR_NONE;
        bus.csr_wdata = '0;
    endtask

    initial begin
        bus.ext_irq  = 1'b0;
        bus.csr_addr = '0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", {31'b0, bus.busy}, 32'h0);
        chk("rst_rv",   {31'b0, bus.redirect_valid}, 32'h0);
        chk("rst_rpc",  bus.redirect_pc, 32'h0);
        rd("rst_mstatus",  CSR_MSTATUS,  32'h0000_1800);
        rd("rst_mie",      CSR_MIE,      32'h0);
        rd("rst_mtvec",    CSR_MTVEC,    32'h0000_0400);
        rd("rst_mscratch", CSR_MSCRATCH, 32'h0);
        rd("rst_mepc",     CSR_MEPC,     32'h0);
        rd("rst_mcause",   CSR_MCAUSE,   32'h0);
        rd("rst_mtval",    CSR_MTVAL,    32'h0);
        rd("rst_mip",      CSR_MIP,      32'h0);
        rd("rst_mhartid",  CSR_MHARTID,  32'h0);
        chk("rst_irqp", {31'b0, bus.irq_pending}, 32'h0);

        // Basic RW/RS/RC with masking
        wr(CSR_RW, CSR_MTVEC, 32'h0000_0103);
        rd("mtvec_rw", CSR_MTVEC, 32'h0000_0100);
        bus.csr_op = CSR_RS; bus.csr_addr = CSR_MSTATUS; bus.csr_wdata = 32'h8;
        #1;
        chk("rs_old_rdata", bus.csr_rdata, 32'h0000_1800);
        tick();
        bus.csr_op = CSR_NONE;
        rd("mstatus_rs", CSR_MSTATUS, 32'h0000_1808);
        wr(CSR_RC, CSR_MSTATUS, 32'h8);
        rd("mstatus_rc", CSR_MSTATUS, 32'h0000_1800);
        wr(CSR_RW, CSR_MSTATUS, 32'hFFFF_FFFF);
        rd("mstatus_rw_mask", CSR_MSTATUS, 32'h0000_1888);
        wr(CSR_RW, CSR_MSTATUS, 32'h0);
        wr(CSR_RW, CSR_MEPC, 32'h0000_1237);
        rd("mepc_align", CSR_MEPC, 32'h0000_1234);

        // Trap entry
        wr(CSR_RS, CSR_MSTATUS, 32'h8);
        bus.trap_req = 1'b1; bus.trap_pc = 32'h2006; bus.trap_cause = 32'h2; bus.trap_tval = 32'hDEAD;
        #1;
        chk("trap_rv_before", {31'b0, bus.redirect_valid}, 32'h0);
        tick();
        idle_inputs();
        chk("trap_rv",   {31'b0, bus.redirect_valid}, 32'h1);
        chk("trap_busy", {31'b0, bus.busy}, 32'h1);
        chk("trap_rpc",  bus.redirect_pc, 32'h0000_0100);
        // Requests and writes during REDIRECT are ignored
        bus.trap_req = 1'b1; bus.trap_pc = 32'h9000; bus.trap_cause = 32'h7; bus.trap_tval = 32'h1;
        bus.csr_op = CSR_RW; bus.csr_addr = CSR_MSCRATCH; bus.csr_wdata = 32'h77;
        tick();
        idle_inputs();
        chk("trap_rv_drop",   {31'b0, bus.redirect_valid}, 32'h0);
        chk("trap_busy_drop", {31'b0, bus.busy}, 32'h0);
        rd("trap_mepc",     CSR_MEPC,     32'h0000_2004);
        rd("trap_mcause",   CSR_MCAUSE,   32'h2);
        rd("trap_mtval",    CSR_MTVAL,    32'hDEAD);
        rd("trap_mstatus",  CSR_MSTATUS,  32'h0000_1880);
        rd("trap_mscratch", CSR_MSCRATCH, 32'h0);

        // mret
        bus.mret_req = 1'b1;
        tick();
        bus.mret_req = 1'b0;
        chk("mret_rv",  {31'b0, bus.redirect_valid}, 32'h1);
        chk("mret_rpc", bus.redirect_pc, 32'h0000_2004);
        tick();
        chk("mret_rv_end", {31'b0, bus.redirect_valid}, 32'h0);
        rd("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

        // Same-cycle trap + mret + CSR write: trap wins
        bus.trap_req = 1'b1; bus.trap_pc = 32'h3000; bus.trap_cause = 32'hB; bus.trap_tval = 32'h0;
        bus.mret_req = 1'b1;
        bus.csr_op = CSR_RW; bus.csr_addr = CSR_MSCRATCH; bus.csr_wdata = 32'h55;
        tick();
        idle_inputs();
        chk("prio_rv",  {31'b0, bus.redirect_valid}, 32'h1);
        chk("prio_rpc", bus.redirect_pc, 32'h0000_0100);
        tick();
        rd("prio_mscratch", CSR_MSCRATCH, 32'h0);
        rd("prio_mepc",     CSR_MEPC,     32'h0000_3000);
        rd("prio_mcause",   CSR_MCAUSE,   32'hB);
        rd("prio_mstatus",  CSR_MSTATUS,  32'h0000_1880);

        // Illegal decode
        bus.csr_op = CSR_RW; bus.csr_addr = CSR_MHARTID; bus.csr_wdata = 32'h5;
        #1;
        chk("hartid_rw_ill", {31'b0, bus.csr_illegal}, 32'h1);
        tick();
        rd("hartid_after", CSR_MHARTID, 32'h0);
        bus.csr_op = CSR_RS; bus.csr_addr = CSR_MHARTID; bus.csr_wdata = 32'h0;
        #1;
        chk("hartid_rs0_legal", {31'b0, bus.csr_illegal}, 32'h0);
        bus.csr_op = CSR_RC; bus.csr_wdata = 32'h1;
        #1;
        chk("hartid_rc1_ill", {31'b0, bus.csr_illegal}, 32'h1);
        bus.csr_op = CSR_RW; bus.csr_addr = 12'h7C0; bus.csr_wdata = 32'h1;
        #1;
        chk("unmapped_ill",   {31'b0, bus.csr_illegal}, 32'h1);
        chk("unmapped_rdata", bus.csr_rdata, 32'h0);
        bus.csr_addr = CSR_MIP;
        #1;
        chk("mip_wr_legal", {31'b0, bus.csr_illegal}, 32'h0);
        bus.csr_op = CSR_NONE; bus.csr_addr = 12'h7C0;
        #1;
        chk("unmapped_read_legal", {31'b0, bus.csr_illegal}, 32'h0);
        tick();

        // Interrupt pending
        wr(CSR_RS, CSR_MIE, 32'hFFFF_FFFF);
        rd("mie_mask", CSR_MIE, 32'h0000_0800);
        wr(CSR_RS, CSR_MSTATUS, 32'h8);
        chk("irqp_noirq", {31'b0, bus.irq_pending}, 32'h0);
        bus.ext_irq = 1'b1;
        #1;
        chk("irqp_on", {31'b0, bus.irq_pending}, 32'h1);
        rd("mip_on", CSR_MIP, 32'h0000_0800);
        wr(CSR_RC, CSR_MSTATUS, 32'h8);
        chk("irqp_mie0", {31'b0, bus.irq_pending}, 32'h0);
        bus.ext_irq = 1'b0;

        // Reset in the middle of a redirect aborts it
        bus.trap_req = 1'b1; bus.trap_pc = 32'h4000; bus.trap_cause = 32'h3;
        tick();
        idle_inputs();
        chk("abort_pre_rv", {31'b0, bus.redirect_valid}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_rv",   {31'b0, bus.redirect_valid}, 32'h0);
        chk("abort_busy", {31'b0, bus.busy}, 32'h0);
        chk("abort_rpc",  bus.redirect_pc, 32'h0);
        rd("abort_mtvec",   CSR_MTVEC,   32'h0000_0400);
        rd("abort_mepc",    CSR_MEPC,    32'h0);
        rd("abort_mstatus", CSR_MSTATUS, 32'h0000_1800);
        tick();
        chk("abort_rv_after", {31'b0, bus.redirect_valid}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
